// File: rtl/conv_sequencer.sv
// conv_sequencer
//
// Control FSM and address generator for the single-multiplier convolution
// datapath. It walks output row, output column, kernel row and kernel column,
// with kernel column innermost. For every tap it issues an input-memory
// address, a kernel-memory address and the accumulator controls. For every
// output pixel it issues one output write.
//
// Optional feature macro: CONV_SEQ_HOLD_EN
//   When defined, the input port `hold` is added. While hold=1 in MAC, DRAIN
//   or WRITE, the block freezes and acc_en/acc_clr/out_we read 0. Execution
//   resumes where it stopped once hold returns to 0.
//
// Parameters:
//   N    width of the dimension registers and loop counters
//   AW   width of all address outputs (addresses wrap modulo 2**AW)
//   LAT  datapath latency from address issue to product at the accumulator
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         begin a convolution (sampled only in IDLE)
//   hold          freeze request (only with CONV_SEQ_HOLD_EN)
//   img_w/img_h   input image width / height
//   ker_k         square kernel size
//   busy          high from the cycle after start is accepted through DONE
//   done          one-cycle completion pulse
//   err           configuration error, valid while done=1
//   in_addr       input memory read address
//   ker_addr      kernel memory read address
//   out_addr      output memory write address
//   acc_clr       first tap of a pixel: accumulator loads the product
//   acc_en        tap valid: accumulate this product
//   out_we        write the accumulator to out_addr
module conv_sequencer #(
    parameter int unsigned N   = 8,
    parameter int unsigned AW  = 16,
    parameter int unsigned LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
`ifdef CONV_SEQ_HOLD_EN
    input  logic          hold,
`endif
    input  logic [N-1:0]  img_w,
    input  logic [N-1:0]  img_h,
    input  logic [N-1:0]  ker_k,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] in_addr,
    output logic [AW-1:0] ker_addr,
    output logic [AW-1:0] out_addr,
    output logic          acc_clr,
    output logic          acc_en,
    output logic          out_we
);

    localparam int unsigned DW     = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int unsigned LAT_M1 = (LAT > 0) ? LAT - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          r_state;

    // Latched configuration and derived output sizes
    logic [N-1:0]    r_w;
    logic [N-1:0]    r_k;
    logic [N-1:0]    r_ow;
    logic [N-1:0]    r_oh;

    // Loop counters
    logic [N-1:0]    r_orow;
    logic [N-1:0]    r_ocol;
    logic [N-1:0]    r_kr;
    logic [N-1:0]    r_kc;
    logic [DW-1:0]   r_drain;

    // Running pointers: r_pix_base = orow*W + ocol (window top-left),
    // r_row_ptr = r_pix_base + kr*W (start of the current kernel row)
    logic [AW-1:0]   r_pix_base;
    logic [AW-1:0]   r_row_ptr;

    // Registered outputs
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [AW-1:0]   r_in_addr;
    logic [AW-1:0]   r_ker_addr;
    logic [AW-1:0]   r_out_addr;
    logic            r_acc_clr;
    logic            r_acc_en;
    logic            r_out_we;

    logic            w_cfg_bad;
    logic            w_last_kc;
    logic            w_last_kr;
    logic            w_last_col;
    logic            w_last_row;
    logic [AW-1:0]   w_w_ext;
    logic [AW-1:0]   w_k_ext;
    logic [AW-1:0]   w_next_base;
    logic            w_hold;

    assign w_cfg_bad  = (ker_k == '0) || (ker_k > img_w) || (ker_k > img_h);
    assign w_last_kc  = (r_kc == r_k - N'(1));
    assign w_last_kr  = (r_kr == r_k - N'(1));
    assign w_last_col = (r_ocol == r_ow - N'(1));
    assign w_last_row = (r_orow == r_oh - N'(1));
    assign w_w_ext    = AW'(r_w);
    assign w_k_ext    = AW'(r_k);

    // Moving one column right adds 1 to the window origin; wrapping from the
    // last column (OW-1) to column 0 of the next row adds W-OW+1 = K.
    assign w_next_base = w_last_col ? (r_pix_base + w_k_ext)
                                    : (r_pix_base + AW'(1));

`ifdef CONV_SEQ_HOLD_EN
    assign w_hold = hold && ((r_state == S_MAC) || (r_state == S_DRAIN) ||
                             (r_state == S_WRITE));
`else
    assign w_hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_w        <= '0;
            r_k        <= '0;
            r_ow       <= '0;
            r_oh       <= '0;
            r_orow     <= '0;
            r_ocol     <= '0;
            r_kr       <= '0;
            r_kc       <= '0;
            r_drain    <= '0;
            r_pix_base <= '0;
            r_row_ptr  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_in_addr  <= '0;
            r_ker_addr <= '0;
            r_out_addr <= '0;
            r_acc_clr  <= 1'b0;
            r_acc_en   <= 1'b0;
            r_out_we   <= 1'b0;
        end else if (!w_hold) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_w        <= img_w;
                        r_k        <= ker_k;
                        r_ow       <= img_w - ker_k + N'(1);
                        r_oh       <= img_h - ker_k + N'(1);
                        r_orow     <= '0;
                        r_ocol     <= '0;
                        r_kr       <= '0;
                        r_kc       <= '0;
                        r_drain    <= '0;
                        r_pix_base <= '0;
                        r_row_ptr  <= '0;
                        r_in_addr  <= '0;
                        r_ker_addr <= '0;
                        r_out_addr <= '0;
                        r_busy     <= 1'b1;
                        if (w_cfg_bad) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err     <= 1'b0;
                            r_acc_en  <= 1'b1;
                            r_acc_clr <= 1'b1;
                            r_state   <= S_MAC;
                        end
                    end
                end

                S_MAC: begin
                    r_acc_clr <= 1'b0;
                    if (!w_last_kc) begin
                        r_kc       <= r_kc + N'(1);
                        r_in_addr  <= r_in_addr + AW'(1);
                        r_ker_addr <= r_ker_addr + AW'(1);
                    end else if (!w_last_kr) begin
                        r_kc       <= '0;
                        r_kr       <= r_kr + N'(1);
                        r_row_ptr  <= r_row_ptr + w_w_ext;
                        r_in_addr  <= r_row_ptr + w_w_ext;
                        r_ker_addr <= r_ker_addr + AW'(1);
                    end else begin
                        r_kc     <= '0;
                        r_kr     <= '0;
                        r_acc_en <= 1'b0;
                        if (LAT == 0) begin
                            r_out_we <= 1'b1;
                            r_state  <= S_WRITE;
                        end else begin
                            r_drain <= '0;
                            r_state <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (r_drain == DW'(LAT_M1)) begin
                        r_out_we <= 1'b1;
                        r_state  <= S_WRITE;
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end

                S_WRITE: begin
                    r_out_we <= 1'b0;
                    if (w_last_col && w_last_row) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        if (w_last_col) begin
                            r_ocol <= '0;
                            r_orow <= r_orow + N'(1);
                        end else begin
                            r_ocol <= r_ocol + N'(1);
                        end
                        r_pix_base <= w_next_base;
                        r_row_ptr  <= w_next_base;
                        r_in_addr  <= w_next_base;
                        r_ker_addr <= '0;
                        r_out_addr <= r_out_addr + AW'(1);
                        r_acc_en   <= 1'b1;
                        r_acc_clr  <= 1'b1;
                        r_state    <= S_MAC;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;
    assign in_addr  = r_in_addr;
    assign ker_addr = r_ker_addr;
    assign out_addr = r_out_addr;

    // A frozen tap must not reach the accumulator, so the strobes are masked
    // in the same cycle that hold is seen.
    assign acc_clr = r_acc_clr & ~w_hold;
    assign acc_en  = r_acc_en  & ~w_hold;
    assign out_we  = r_out_we  & ~w_hold;

endmodule
